// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end of the pipelined MIPS core.
// It issues one word read per cycle while queue credit remains and tags each
// returned instruction with its PC. Instructions go to decode through a small
// queue with a valid/ready handshake. A branch/jump redirect flushes the queue.
module if_fetch_unit #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] PcIn,
   output logic [ADDR_W-1:0] PcNext,
   output logic              ImemReq,
   output logic [ADDR_W-1:0] ImemAddr,
   input  logic [DATA_W-1:0] ImemData,
   input  logic              RedirectValid,
   input  logic [ADDR_W-1:0] RedirectPc,
   output logic              InstrValid,
   output logic [DATA_W-1:0] InstrData,
   output logic [ADDR_W-1:0] InstrPc,
   input  logic              InstrReady
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [PW-1:0]     head_q, head_d;
   logic [PW-1:0]     tail_q, tail_d;
   logic [CW-1:0]     count_q, count_d;
   logic              inflight_q, inflight_d;
   logic [ADDR_W-1:0] inflightPc_q, inflightPc_d;
   logic              kill_q, kill_d;

   logic [ADDR_W-1:0] pcMem_q   [DEPTH];
   logic [DATA_W-1:0] dataMem_q [DEPTH];

   logic [CW:0]       occupancy;
   logic              issue;
   logic              push;
   logic              pop;

   // Credit check, handshake decode and the combinational PC/memory outputs;
   // everything is forced quiet while reset is held.
   always_comb begin
      occupancy  = {1'b0, count_q} + (CW+1)'(inflight_q);
      issue      = rst && !RedirectValid && (occupancy < (CW+1)'(DEPTH));
      InstrValid = (count_q != '0);
      pop        = InstrValid && InstrReady && !RedirectValid;
      push       = inflight_q && !kill_q && !RedirectValid;
      ImemReq    = issue;
      ImemAddr   = PcIn;
      InstrData  = '0;
      InstrPc    = '0;
      if (InstrValid) begin
         InstrData = dataMem_q[head_q];
         InstrPc   = pcMem_q[head_q];
      end
      if (!rst) begin
         PcNext = '0;
      end else if (RedirectValid) begin
         PcNext = RedirectPc;
      end else if (issue) begin
         PcNext = PcIn + ADDR_W'(1);
      end else begin
         PcNext = PcIn;
      end
   end

   // Next-state for queue pointers, occupancy and the in-flight/kill tracking;
   // a redirect overrides any push or pop in the same cycle.
   always_comb begin
      head_d       = head_q;
      tail_d       = tail_q;
      count_d      = count_q;
      inflight_d   = issue;
      inflightPc_d = inflightPc_q;
      kill_d       = 1'b0;
      if (issue) begin
         inflightPc_d = PcIn;
      end
      if (RedirectValid) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
         kill_d  = inflight_q;
      end else begin
         if (pop) begin
            head_d = head_q + PW'(1);
         end
         if (push) begin
            tail_d = tail_q + PW'(1);
         end
         case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Control state register; reset drops any outstanding memory response.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head_q       <= '0;
         tail_q       <= '0;
         count_q      <= '0;
         inflight_q   <= 1'b0;
         inflightPc_q <= '0;
         kill_q       <= 1'b0;
      end else begin
         head_q       <= head_d;
         tail_q       <= tail_d;
         count_q      <= count_d;
         inflight_q   <= inflight_d;
         inflightPc_q <= inflightPc_d;
         kill_q       <= kill_d;
      end
   end

   // Queue storage needs no reset because entries are only visible below count.
   always_ff @(posedge clk) begin
      if (push) begin
         pcMem_q[tail_q]   <= inflightPc_q;
         dataMem_q[tail_q] <= ImemData;
      end
   end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed table, corner sequences and
// random traffic compared against a queue-based reference model.
module tb_if_fetch_unit;

   localparam int DEPTH = 4;

   logic        clk;
   logic        rst;
   logic [31:0] pcReg;
   logic [31:0] pcNext;
   logic        imemReq;
   logic [31:0] imemAddr;
   logic [31:0] memData;
   logic        redirValid;
   logic [31:0] redirPc;
   logic        instrValid;
   logic [31:0] instrData;
   logic [31:0] instrPc;
   logic        instrReady;

   int checkCount;
   int passCount;

   // Reference model state: queued PCs in order, one outstanding read, kill flag.
   logic [31:0] qPc[$];
   bit          mInfl;
   logic [31:0] mInflPc;
   bit          mKill;

   // Values seen at the most recent sample point.
   logic        sampReq;
   logic [31:0] sampPcNext;
   logic        sampValid;
   logic [31:0] sampPc;
   logic [31:0] sampData;

   typedef struct {
      logic        ready;
      logic        expReq;
      logic [31:0] expPcNext;
      logic        expValid;
      logic [31:0] expPc;
   } vecT;

   vecT vecs[12];

   if_fetch_unit #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH)) dut (
      .clk           (clk),
      .rst           (rst),
      .PcIn          (pcReg),
      .PcNext        (pcNext),
      .ImemReq       (imemReq),
      .ImemAddr      (imemAddr),
      .ImemData      (memData),
      .RedirectValid (redirValid),
      .RedirectPc    (redirPc),
      .InstrValid    (instrValid),
      .InstrData     (instrData),
      .InstrPc       (instrPc),
      .InstrReady    (instrReady)
   );

   // Free-running clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] instrOf(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checkCount++;
      if (act === exp) passCount++;
      else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic modelClear();
      qPc.delete();
      mInfl   = 1'b0;
      mInflPc = '0;
      mKill   = 1'b0;
   endtask

   // One bus cycle: drive inputs, compare against the model, then advance it.
   task automatic applyStimulus(input logic ready, input logic redir, input logic [31:0] rpc);
      int          occ;
      bit          expIssue;
      logic [31:0] expNext;
      logic [31:0] oldPc;
      bit          wasValid;
      instrReady = ready;
      redirValid = redir;
      redirPc    = rpc;
      occ      = qPc.size() + (mInfl ? 1 : 0);
      expIssue = !redir && (occ < DEPTH);
      expNext  = redir ? rpc : (expIssue ? pcReg + 32'd1 : pcReg);
      wasValid = (qPc.size() != 0);
      @(negedge clk);
      sampReq    = imemReq;
      sampPcNext = pcNext;
      sampValid  = instrValid;
      sampPc     = instrPc;
      sampData   = instrData;
      checkOutput("ImemReq", {31'd0, imemReq}, {31'd0, expIssue});
      checkOutput("PcNext", pcNext, expNext);
      checkOutput("ImemAddr", imemAddr, pcReg);
      checkOutput("InstrValid", {31'd0, instrValid}, {31'd0, wasValid});
      if (wasValid) begin
         checkOutput("InstrPc", instrPc, qPc[0]);
         checkOutput("InstrData", instrData, instrOf(qPc[0]));
      end
      @(posedge clk);
      #1;
      oldPc = pcReg;
      if (redir) begin
         qPc.delete();
         mKill = mInfl;
         mInfl = 1'b0;
      end else begin
         if (wasValid && ready) void'(qPc.pop_front());
         if (mInfl && !mKill) qPc.push_back(mInflPc);
         mKill = 1'b0;
         mInfl = (occ < DEPTH);
         if (mInfl) mInflPc = oldPc;
      end
      pcReg   = expNext;
      memData = instrOf(oldPc);
   endtask

   task automatic doReset(input logic [31:0] startPc);
      rst        = 1'b0;
      instrReady = 1'b0;
      redirValid = 1'b0;
      redirPc    = '0;
      repeat (2) @(posedge clk);
      #1;
      pcReg = startPc;
      modelClear();
      rst = 1'b1;
   endtask

   // Run up to a bounded number of cycles waiting for a valid head, then check its PC.
   task automatic expectFirstPc(input string name, input logic [31:0] exp);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 8 && !seen; i++) begin
         applyStimulus(1'b1, 1'b0, '0);
         if (sampValid) begin
            seen = 1'b1;
            checkOutput(name, sampPc, exp);
         end
      end
      if (!seen) checkOutput({name, "_timeout"}, 32'd0, 32'd1);
   endtask

   initial begin
      checkCount = 0;
      passCount  = 0;
      pcReg      = '0;
      memData    = '0;
      rst        = 1'b0;
      instrReady = 1'b0;
      redirValid = 1'b0;
      redirPc    = '0;
      modelClear();

      // Fill with decode stalled, then release.
      vecs[0]  = '{1'b0, 1'b1, 32'd1, 1'b0, 32'd0};
      vecs[1]  = '{1'b0, 1'b1, 32'd2, 1'b0, 32'd0};
      vecs[2]  = '{1'b0, 1'b1, 32'd3, 1'b1, 32'd0};
      vecs[3]  = '{1'b0, 1'b1, 32'd4, 1'b1, 32'd0};
      vecs[4]  = '{1'b0, 1'b0, 32'd4, 1'b1, 32'd0};
      vecs[5]  = '{1'b0, 1'b0, 32'd4, 1'b1, 32'd0};
      vecs[6]  = '{1'b0, 1'b0, 32'd4, 1'b1, 32'd0};
      vecs[7]  = '{1'b1, 1'b0, 32'd4, 1'b1, 32'd0};
      vecs[8]  = '{1'b1, 1'b1, 32'd5, 1'b1, 32'd1};
      vecs[9]  = '{1'b1, 1'b1, 32'd6, 1'b1, 32'd2};
      vecs[10] = '{1'b1, 1'b1, 32'd7, 1'b1, 32'd3};
      vecs[11] = '{1'b1, 1'b1, 32'd8, 1'b1, 32'd4};

      // Reset state.
      #2;
      checkOutput("rstValid", {31'd0, instrValid}, 32'd0);
      checkOutput("rstReq", {31'd0, imemReq}, 32'd0);
      checkOutput("rstPcNext", pcNext, 32'd0);
      checkOutput("rstInstrPc", instrPc, 32'd0);
      checkOutput("rstInstrData", instrData, 32'd0);

      // Table-driven fill and drain.
      doReset(32'd0);
      for (int i = 0; i < 12; i++) begin
         applyStimulus(vecs[i].ready, 1'b0, '0);
         checkOutput($sformatf("tblReq%0d", i), {31'd0, sampReq}, {31'd0, vecs[i].expReq});
         checkOutput($sformatf("tblPcNext%0d", i), sampPcNext, vecs[i].expPcNext);
         checkOutput($sformatf("tblValid%0d", i), {31'd0, sampValid}, {31'd0, vecs[i].expValid});
         if (vecs[i].expValid)
            checkOutput($sformatf("tblPc%0d", i), sampPc, vecs[i].expPc);
      end

      // Steady stream, then redirect while PC 5 is in flight.
      doReset(32'd0);
      for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, '0);
      applyStimulus(1'b1, 1'b1, 32'h100);
      applyStimulus(1'b1, 1'b0, '0);
      checkOutput("redirValidLow", {31'd0, sampValid}, 32'd0);
      applyStimulus(1'b1, 1'b0, '0);
      checkOutput("redirStillLow", {31'd0, sampValid}, 32'd0);
      applyStimulus(1'b1, 1'b0, '0);
      checkOutput("redirTgtValid", {31'd0, sampValid}, 32'd1);
      checkOutput("redirTgtPc", sampPc, 32'h100);
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, '0);

      // Redirect with two queued entries and decode ready, then back-to-back redirects.
      doReset(32'd0);
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, '0);
      applyStimulus(1'b1, 1'b1, 32'h500);
      checkOutput("flushHeadPc", sampPc, 32'd0);
      applyStimulus(1'b1, 1'b1, 32'h40);
      checkOutput("flushEmpty", {31'd0, sampValid}, 32'd0);
      applyStimulus(1'b1, 1'b1, 32'h80);
      expectFirstPc("b2bFirstPc", 32'h80);
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, '0);

      // PC wrap at the top of the address space.
      applyStimulus(1'b1, 1'b1, 32'hFFFF_FFFF);
      applyStimulus(1'b1, 1'b0, '0);
      checkOutput("wrapPcNext", sampPcNext, 32'h0);
      expectFirstPc("wrapTag", 32'hFFFF_FFFF);
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, '0);

      // Asynchronous reset with three entries queued and one in flight.
      doReset(32'd0);
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, '0);
      #3;
      rst = 1'b0;
      #1;
      checkOutput("arstValid", {31'd0, instrValid}, 32'd0);
      checkOutput("arstReq", {31'd0, imemReq}, 32'd0);
      checkOutput("arstPcNext", pcNext, 32'd0);
      checkOutput("arstInstrPc", instrPc, 32'd0);
      checkOutput("arstInstrData", instrData, 32'd0);
      doReset(32'h200);
      expectFirstPc("arstRestartPc", 32'h200);
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, '0);

      // Random traffic against the model.
      for (int i = 0; i < 400; i++) begin
         logic        rdy;
         logic        rd;
         logic [31:0] tgt;
         rdy = ($urandom_range(0, 3) != 0);
         rd  = ($urandom_range(0, 15) == 0);
         tgt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFE : $urandom;
         applyStimulus(rdy, rd, tgt);
      end

      $display("[TB] %0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
